// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor A-B-Bin with parallel result.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             d_bit,
  output logic             d_valid,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             done,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] res;
  logic             bit_d;
  logic             br_nx;
  logic [WIDTH-1:0] res_cat;

  assign bit_d   = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nx   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  // New bit enters at the top; after WIDTH shifts bit k sits at index k.
  assign res_cat = {bit_d, res};

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      res     <= '0;
      busy    <= 1'b0;
      d_bit   <= 1'b0;
      d_valid <= 1'b0;
      D       <= '0;
      Bout    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          d_valid <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          d_bit   <= bit_d;
          d_valid <= 1'b1;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          br      <= br_nx;
          res     <= res_cat[WIDTH-1:1];
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            D     <= res_cat;
            Bout  <= br_nx;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf   <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy, d_bit, d_valid, Bout, done, ovf;
  logic [W-1:0] D;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] exp_d = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .d_bit(d_bit), .d_valid(d_valid), .D(D), .Bout(Bout),
    .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Starts one operation and follows it to its done cycle; optionally pokes start/operands mid-run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit disturb);
    int           full;
    logic [W-1:0] diff;
    logic         bout_m, ovf_m;
    full   = int'(a) - int'(b) - int'(bin);
    diff   = W'(full);
    bout_m = (int'(a) < int'(b) + int'(bin));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_m  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
`else
    ovf_m  = 1'b0;
`endif
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || d_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: busy=%b d_valid=%b done=%b, want 1 0 0", busy, d_valid, done);
    end
    for (int k = 0; k < W; k++) begin
      if (disturb && k == 2) begin A = 8'hFF; B = 8'h00; Bin = 1'b1; start = 1'b1; end
      if (disturb && k == 3) start = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (d_valid !== 1'b1 || d_bit !== diff[k]) begin
        n_fail++;
        $display("FAIL serial_bit%0d: d_valid=%b d_bit=%b, want 1 %b", k, d_valid, d_bit, diff[k]);
      end
      if (k < W - 1) begin
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || D !== exp_d || Bout !== exp_bout || ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL run_hold%0d: busy=%b done=%b D=%h Bout=%b ovf=%b, want 1 0 %h %b %b",
                   k, busy, done, D, Bout, ovf, exp_d, exp_bout, exp_ovf);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || D !== diff || Bout !== bout_m || ovf !== ovf_m) begin
      n_fail++;
      $display("FAIL result %h-%h-%b: done=%b busy=%b D=%h Bout=%b ovf=%b, want 1 0 %h %b %b",
               a, b, bin, done, busy, D, Bout, ovf, diff, bout_m, ovf_m);
    end
    exp_d = diff; exp_bout = bout_m; exp_ovf = ovf_m;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || d_valid !== 1'b0 || D !== exp_d || Bout !== exp_bout) begin
        n_fail++;
        $display("FAIL idle: done=%b busy=%b d_valid=%b D=%h Bout=%b, want 0 0 0 %h %b",
                 done, busy, d_valid, D, Bout, exp_d, exp_bout);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (busy !== 1'b0 || d_bit !== 1'b0 || d_valid !== 1'b0 || D !== '0 || Bout !== 1'b0 ||
        done !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b d_bit=%b d_valid=%b D=%h Bout=%b done=%b ovf=%b, want all 0",
               busy, d_bit, d_valid, D, Bout, done, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    run_op(8'h05, 8'h03, 1'b0, 1'b0); idle_cycles(1);
    run_op(8'h03, 8'h05, 1'b0, 1'b0); idle_cycles(1);
    run_op(8'h00, 8'h00, 1'b1, 1'b0); idle_cycles(1);
    run_op(8'h80, 8'h01, 1'b0, 1'b0); idle_cycles(1);
    run_op(8'h10, 8'h01, 1'b0, 1'b0); idle_cycles(1);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0); idle_cycles(1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0); idle_cycles(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      idle_cycles(int'($urandom_range(1, 2)));
    end
  endtask

  task automatic test_ignore_start();
    run_op(8'h09, 8'h04, 1'b0, 1'b1);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    run_op(8'h09, 8'h04, 1'b0, 1'b0);
    run_op(8'h20, 8'h31, 1'b1, 1'b0);
    run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_run();
    A = 8'h09; B = 8'h04; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || d_bit !== 1'b0 || d_valid !== 1'b0 || D !== '0 || Bout !== 1'b0 ||
        done !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b d_bit=%b d_valid=%b D=%h Bout=%b done=%b ovf=%b, want all 0",
               busy, d_bit, d_valid, D, Bout, done, ovf);
    end
    exp_d = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h09, 8'h04, 1'b0, 1'b0);
    idle_cycles(3);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 A  input  WIDTH  minuend; captured on accepted start.
REQ-006 B  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 Bin  input  1  borrow-in; captured on accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 d_bit  output  1  current serial difference bit, LSB first.
REQ-010 d_valid  output  1  qualifies d_bit; high for exactly WIDTH cycles per operation.
REQ-011 D  output  WIDTH  parallel difference A-B-Bin, held until next completion.
REQ-012 Bout  output  1  final borrow-out, held with D.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 ovf  output  1  signed overflow flag, held with D (see Configuration).

Function
REQ-015 FSM shall have two states: IDLE, RUN.
REQ-016 IDLE -> RUN on a rising edge with start=1; A, B and Bin shall be loaded into internal shift registers and the borrow register, and the bit counter cleared.
REQ-017 Each RUN cycle shall process one bit, LSB first: d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
REQ-018 d_bit/d_valid shall be registered outputs: the bit computed on RUN edge k (k=0..WIDTH-1) shall appear on d_bit, with d_valid=1, for the cycle following that edge.
REQ-019 Difference bits shall be shifted into the result register MSB-first, so that bit k lands in D[k] after WIDTH shifts.
REQ-020 RUN -> IDLE on the WIDTH-th RUN edge (counter = WIDTH-1); on that same edge D, Bout and ovf shall update, and done shall be 1 for the following cycle only.
REQ-021 Latency: start sampled at edge t0 -> done high in the cycle after edge t0+WIDTH; busy high from t0 to t0+WIDTH.
REQ-022 start while busy=1 shall be ignored, with no effect on operands or state.
REQ-023 start=1 in the done cycle shall be accepted, giving back-to-back operations with no idle gap.
REQ-024 D, Bout and ovf shall change only at completion; operand input changes during RUN shall have no effect.
REQ-025 Results are modulo 2^WIDTH; Bout=1 iff A < B+Bin (unsigned).

Reset
REQ-026 rst_n=0 shall immediately force IDLE and clear the counter, the shift registers, busy, d_bit, d_valid, D, Bout, done and ovf to 0.
REQ-027 Reset during RUN shall abort the operation: no done pulse, and D is not updated.
REQ-028 The first start shall be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SERIAL_SUBTRACTOR_OVF_EN: when defined, ovf = (A[MSB]!=B[MSB]) && (D[MSB]!=A[MSB]) for the captured operands, updated at completion.
REQ-030 When SERIAL_SUBTRACTOR_OVF_EN is undefined, the ovf port shall remain present, be tied to 0, and no overflow logic shall be synthesized.

Verification (WIDTH=8)
REQ-031 A=0x05, B=0x03, Bin=0, start one cycle -> d_bit stream 0,1,0,0,0,0,0,0; after 8 edges D=0x02, Bout=0, done one cycle.
REQ-032 A=0x03, B=0x05, Bin=0 -> D=0xFE, Bout=1; A=0x00, B=0x00, Bin=1 -> D=0xFF, Bout=1.
REQ-033 With OVF_EN: A=0x80, B=0x01 -> D=0x7F, ovf=1; A=0x10, B=0x01 -> D=0x0F, ovf=0. Without OVF_EN, ovf stays 0 for both cases.
REQ-034 Start 0x09-0x04, then pulse start with A=0xFF during RUN -> second start ignored; D=0x05. Then start held high in the done cycle -> second operation begins immediately.
REQ-035 Assert rst_n=0 at RUN cycle 4 -> all outputs 0 immediately, no done pulse; a new start after release gives the correct result.
